// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Provides the BCD digit type, the scan FSM state type and the active-low
// segment patterns (bit order gfedcba, seg[6] = g).
package seg_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/bcd7seg.sv
// BCD to seven-segment decoder, active-low outputs (gfedcba).
// Ports:
//   bcd_i  - 4-bit BCD code
//   seg_o  - active-low segment pattern; codes 10..15 give all segments off
module bcd7seg
    import seg_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_DIGIT[bcd_i];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Holds a double-buffered frame of BCD digits and steps one shared decoder
// across the digits, starting each digit slot with an all-off blanking gap.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - strobe capturing digits_in / dp_in into the pending buffer
//   digits_in  - BCD frame, bits [3:0] = digit 0 (rightmost, an[0])
//   dp_in      - decimal point enables, active-high
//   blank_lz   - live leading-zero blanking enable
//   an         - anode selects, active-low
//   seg        - segment cathodes, active-low, gfedcba
//   dp         - decimal point cathode, active-low
//   upd_ack    - one-cycle pulse when the displayed frame is replaced
//
// state | meaning
// GAP   | first BLANK_CYCLES clocks of a slot, all anodes off
// SHOW  | rest of the slot, anode idx driven with its decoded digit
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    upd_ack
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]         PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]         BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, pend_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, pend_dp_q;
    logic                    pend_v_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    upd_ack_q;

    logic                    slot_end, frame_wrap;
    scan_state_t             state_d;
    bcd_t                    shadow_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_run;
    logic [6:0]              dec_seg;

    assign slot_end   = (pcnt_q == PCNT_LAST);
    assign frame_wrap = slot_end && (idx_q == IDX_LAST);
    assign pcnt_d     = slot_end ? '0 : pcnt_q + 1'b1;
    assign idx_d      = slot_end ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
    assign state_d    = (pcnt_q < BLANK_END) ? GAP : SHOW;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_arr[i] = shadow_q[4*i +: 4];
        end
    end

    // A digit is a leading zero when it and every digit above it are zero;
    // walking down from the top keeps a running "all zero so far" flag.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (shadow_arr[i] == 4'd0);
            lz_blank[i] = blank_lz && zero_run;
        end
        lz_blank[0] = 1'b0;
    end

    bcd7seg u_dec (
        .bcd_i (shadow_arr[idx_q]),
        .seg_o (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_v_q    <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            upd_ack_q   <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            upd_ack_q <= 1'b0;

            // A load landing on the wrap goes straight to the display so it
            // is not held back a whole extra frame.
            if (load && frame_wrap) begin
                shadow_q    <= digits_in;
                shadow_dp_q <= dp_in;
                pend_v_q    <= 1'b0;
                upd_ack_q   <= 1'b1;
            end else if (load) begin
                pend_q    <= digits_in;
                pend_dp_q <= dp_in;
                pend_v_q  <= 1'b1;
            end else if (frame_wrap && pend_v_q) begin
                shadow_q    <= pend_q;
                shadow_dp_q <= pend_dp_q;
                pend_v_q    <= 1'b0;
                upd_ack_q   <= 1'b1;
            end

            case (state_d)
                GAP: begin
                    an_q  <= '1;
                    seg_q <= SEG_BLANK;
                    dp_q  <= 1'b1;
                end
                SHOW: begin
                    an_q  <= ~(AN_ONE << idx_q);
                    seg_q <= lz_blank[idx_q] ? SEG_BLANK : dec_seg;
                    dp_q  <= ~shadow_dp_q[idx_q];
                end
                default: begin
                    an_q  <= '1;
                    seg_q <= SEG_BLANK;
                    dp_q  <= 1'b1;
                end
            endcase
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign upd_ack = upd_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        upd_ack;

    int checks   = 0;
    int failures = 0;
    int tcyc     = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .upd_ack   (upd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s tcyc=%0d observed=%0h expected=%0h", tag, tcyc, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, and check that
    // no two anodes are ever driven together.
    task automatic tick();
        @(posedge clk);
        #1;
        tcyc++;
        chk("an_overlap", 32'($countones(~an) <= 1), 32'd1);
    endtask

    // Walks one full frame (32 clocks) starting at a frame boundary and checks
    // every output cycle. es packs expected segments {d3,d2,d1,d0}, edp the
    // expected active-low dp per digit. Up to two loads are applied at the
    // given offsets within the frame (offset 31 is the frame_wrap cycle).
    task automatic frame_check(input logic [27:0] es, input logic [3:0] edp, input logic eack,
                               input int o1, input logic [15:0] v1, input logic [3:0] p1,
                               input int o2, input logic [15:0] v2, input logic [3:0] p2);
        int p, d;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        chk("upd_ack_frame_start", 32'(upd_ack), 32'(eack));
        for (int j = 1; j <= 32; j++) begin
            if (j - 1 == o1) begin
                load = 1'b1; digits_in = v1; dp_in = p1;
            end else if (j - 1 == o2) begin
                load = 1'b1; digits_in = v2; dp_in = p2;
            end
            tick();
            load = 1'b0;
            p = (j - 1) % 8;
            d = (j - 1) / 8;
            if (p < 2) begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                exp_an  = ~(4'b0001 << d);
                exp_seg = es[d*7 +: 7];
                exp_dp  = edp[d];
            end
            chk("an", 32'(an), 32'(exp_an));
            chk("seg", 32'(seg), 32'(exp_seg));
            chk("dp", 32'(dp), 32'(exp_dp));
            if (j < 32) chk("upd_ack_mid", 32'(upd_ack), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_lz = 1'b0;
        tick(); tick(); tick();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_ack", 32'(upd_ack), 32'd0);

        rst = 1'b0;
        tcyc = 0;
        chk("post_rst_an", 32'(an), 32'hF);
        // F0: all zeros shown
        frame_check({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // F1: still zeros, load 1234 mid-frame
        frame_check({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0, 8, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
        // F2: 1234 shown
        frame_check({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        blank_lz = 1'b1;
        // F3: no leading zeros in 1234, load 0050 with dp on digit 2
        frame_check({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b0, 4, 16'h0050, 4'b0100, -1, 16'h0, 4'h0);
        // F4: 0050 with leading-zero blanking, dp kept on blanked digit 2
        frame_check({7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1011, 1'b1, 10, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
        // F5: 0000 shows only digit 0; loads A then B before the wrap
        frame_check({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 1'b1, 5, 16'h5678, 4'h0, 20, 16'h9012, 4'h0);
        // F6: only B shown; load C exactly on the frame_wrap cycle
        frame_check({7'h10, 7'h40, 7'h79, 7'h24}, 4'hF, 1'b1, 31, 16'h7B38, 4'b0001, -1, 16'h0, 4'h0);
        // F7: C shown immediately, invalid code B blanks with anode driven
        frame_check({7'h78, 7'h7F, 7'h30, 7'h00}, 4'b1110, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Bypass load must not leave a second update pending
        chk("no_second_ack", 32'(upd_ack), 32'd0);

        // Pend a load, then reset during the an[2] slot
        load = 1'b1; digits_in = 16'h1111; dp_in = 4'hF;
        tick();
        load = 1'b0;
        for (int k = 0; k < 200 && tcyc != 276; k++) tick();
        chk("reach_slot2", 32'(tcyc), 32'd276);
        chk("slot2_an", 32'(an), 32'hB);
        rst = 1'b1; blank_lz = 1'b0;
        tick(); tick();
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_dp", 32'(dp), 32'd1);
        chk("mid_rst_ack", 32'(upd_ack), 32'd0);
        rst = 1'b0;
        tcyc = 0;
        frame_check({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        frame_check({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        chk("no_ack_after_rst", 32'(upd_ack), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
